head_and_tail_add: RTL

Receive-side counterpart of the TSMP agent's GMII transmit path. It samples a GMII receive stream already in the i_clk domain, strips preamble and SFD, and optionally strips the 4-byte FCS. It emits frame bytes as 9-bit words with bit 8 flagging the head byte and the tail byte, the same format the transmit path consumes. It sits between the GMII RX interface of the hardware control point and the TSMP frame parser.

---
 rtl/head_and_tail_add.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/head_and_tail_add.sv
`default_nettype none
// ============================================================================
// Module   : head_and_tail_add
// Purpose  : GMII receive framer. Strips preamble/SFD (and, optionally, the
//            4-byte FCS) from an i_clk-domain GMII RX stream and emits frame
//            bytes as 9-bit words, bit 8 marking the head and the tail byte.
// Options  : HEAD_AND_TAIL_ADD_FCS_STRIP_EN - when defined, the last four
//            bytes of every frame (FCS) are held back and never emitted.
// Revision : 1.0 - initial release
// ============================================================================
module head_and_tail_add #(
    parameter int MAX_FRAME_LEN = 2047
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] iv_gmii_rxd,
    input  logic       i_gmii_rx_dv,
    input  logic       i_gmii_rx_er,
    output logic [8:0] ov_data,
    output logic       o_data_wr,
    output logic       o_pkt_pulse,
    output logic       o_pkt_error_pulse
);

    // ------------------------------------------------------------------------
    // Delay-line depth: one byte of look-ahead is always needed so the tail
    // can be marked when dv falls; FCS stripping adds four more bytes that
    // are still in the line when the frame ends and are simply dropped.
    // ------------------------------------------------------------------------
`ifdef HEAD_AND_TAIL_ADD_FCS_STRIP_EN
    localparam int FCS_LEN = 4;
`else
    localparam int FCS_LEN = 0;
`endif
    localparam int          DEPTH    = 1 + FCS_LEN;
    localparam int          LINE_W   = 8 * DEPTH;
    localparam logic [10:0] DEPTH_N  = 11'(DEPTH);
    localparam logic [10:0] MAX_N    = 11'(MAX_FRAME_LEN);
    localparam logic [7:0]  PRE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE = 8'hD5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRE     = 2'd1,
        ST_DATA    = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    state_t            state_q;
    logic [10:0]       cnt_q;       // bytes received since SFD
    logic [LINE_W-1:0] line_q;      // newest byte in [7:0], oldest at the top
    logic [LINE_W-1:0] line_d;      // line after pushing the current byte
    logic              dv_prev_q;   // dv one cycle ago; forced high by reset

    logic [7:0]        w_oldest;    // byte index cnt_q-DEPTH once cnt_q >= DEPTH
    logic              w_line_full; // a byte is ready to leave the line
    logic              w_clean_end; // dv fell without an error
    logic              w_abort;     // rx_er or oversize while in DATA
    logic              w_new_burst; // dv rose since last cycle

    // ------------------------------------------------------------------------
    // Shift path of the delay line. A depth of one is just a holding register
    // and has no lower bytes to carry forward.
    // ------------------------------------------------------------------------
    generate
        if (DEPTH == 1) begin : g_line_single
            assign line_d = iv_gmii_rxd;
        end else begin : g_line_multi
            assign line_d = {line_q[LINE_W-9:0], iv_gmii_rxd};
        end
    endgenerate

    assign w_oldest    = line_q[LINE_W-1 -: 8];
    assign w_line_full = (cnt_q >= DEPTH_N);
    assign w_clean_end = !i_gmii_rx_dv && !i_gmii_rx_er;
    // Byte MAX_FRAME_LEN (zero-based) would push the count past the limit.
    assign w_abort     = i_gmii_rx_er || (cnt_q == MAX_N);
    // dv_prev_q resets high so that a burst already in flight when reset is
    // released never looks like a fresh preamble.
    assign w_new_burst = i_gmii_rx_dv && !dv_prev_q;

    // Receive state machine, delay line, byte counter and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q           <= ST_IDLE;
            cnt_q             <= 11'd0;
            line_q            <= '0;
            dv_prev_q         <= 1'b1;
            ov_data           <= 9'h000;
            o_data_wr         <= 1'b0;
            o_pkt_pulse       <= 1'b0;
            o_pkt_error_pulse <= 1'b0;
        end else begin
            dv_prev_q         <= i_gmii_rx_dv;
            o_data_wr         <= 1'b0;
            o_pkt_pulse       <= 1'b0;
            o_pkt_error_pulse <= 1'b0;

            case (state_q)
                // Wait for the first byte of a burst and classify it.
                ST_IDLE: begin
                    cnt_q <= 11'd0;
                    if (i_gmii_rx_dv) begin
                        if (!w_new_burst) begin
                            // Tail end of a burst that began before reset.
                            state_q <= ST_DISCARD;
                        end else if (i_gmii_rx_er) begin
                            state_q           <= ST_DISCARD;
                            o_pkt_error_pulse <= 1'b1;
                        end else if (iv_gmii_rxd == PRE_BYTE) begin
                            state_q <= ST_PRE;
                        end else if (iv_gmii_rxd == SFD_BYTE) begin
                            // Short preamble: SFD as the very first byte.
                            state_q <= ST_DATA;
                        end else begin
                            state_q           <= ST_DISCARD;
                            o_pkt_error_pulse <= 1'b1;
                        end
                    end
                end

                // Inside the preamble: more 0x55, then SFD.
                ST_PRE: begin
                    cnt_q <= 11'd0;
                    if (!i_gmii_rx_dv) begin
                        state_q           <= ST_IDLE;
                        o_pkt_error_pulse <= 1'b1;
                    end else if (i_gmii_rx_er) begin
                        state_q           <= ST_DISCARD;
                        o_pkt_error_pulse <= 1'b1;
                    end else if (iv_gmii_rxd == SFD_BYTE) begin
                        state_q <= ST_DATA;
                    end else if (iv_gmii_rxd != PRE_BYTE) begin
                        state_q           <= ST_DISCARD;
                        o_pkt_error_pulse <= 1'b1;
                    end
                end

                // Frame body: push bytes, emit the one falling out of the
                // line, and close the frame on dv low, rx_er or oversize.
                ST_DATA: begin
                    if (w_clean_end) begin
                        // Normal end: the oldest held byte is the tail.
                        if (w_line_full) begin
                            ov_data     <= {1'b1, w_oldest};
                            o_data_wr   <= 1'b1;
                            o_pkt_pulse <= 1'b1;
                        end else begin
                            o_pkt_error_pulse <= 1'b1;  // runt
                        end
                        cnt_q   <= 11'd0;
                        state_q <= ST_IDLE;
                    end else if (w_abort) begin
                        // Close what was already headed, but flag it bad.
                        if (w_line_full) begin
                            ov_data   <= {1'b1, w_oldest};
                            o_data_wr <= 1'b1;
                        end
                        o_pkt_error_pulse <= 1'b1;
                        cnt_q             <= 11'd0;
                        state_q           <= i_gmii_rx_dv ? ST_DISCARD : ST_IDLE;
                    end else begin
                        if (w_line_full) begin
                            // Byte index 0 leaves exactly when cnt_q == DEPTH.
                            ov_data   <= {(cnt_q == DEPTH_N), w_oldest};
                            o_data_wr <= 1'b1;
                        end
                        line_q <= line_d;
                        cnt_q  <= cnt_q + 11'd1;
                    end
                end

                // Drop everything until the carrier goes away.
                ST_DISCARD: begin
                    cnt_q <= 11'd0;
                    if (!i_gmii_rx_dv) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    cnt_q   <= 11'd0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
